// File: rtl/tmr0_wdt_if.sv
// CPU-side signal bundle for the Timer-0 prescaler / watchdog block.
// The master drives the instruction strobes and the T0CKI pin; the slave returns the strobes and state.
interface tmr0_wdt_if;
  logic       option_wr;
  logic [5:0] option_in;
  logic       tmr0_wr;
  logic       clrwdt;
  logic       sleep;
  logic       t0cki;
  logic       tmr0_inc;
  logic       wdtmr;
  logic [5:0] option;
  logic       sleeping;

  modport master (
    output option_wr, option_in, tmr0_wr, clrwdt, sleep, t0cki,
    input  tmr0_inc, wdtmr, option, sleeping
  );

  modport slave (
    input  option_wr, option_in, tmr0_wr, clrwdt, sleep, t0cki,
    output tmr0_inc, wdtmr, option, sleeping
  );
endinterface

// File: rtl/tmr0_wdt.sv
// Timer-0 prescaler, T0CKI edge detector, OPTION register and watchdog/sleep tracking.
// Watchdog logic is present only when MINICPU_WDT_EN is defined.
module tmr0_wdt #(
  parameter int WDT_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  tmr0_wdt_if.slave   bus
);

  logic [5:0] option_q, option_d;
  logic [7:0] psc_q, psc_d;
  logic       s1_q, s2_q, s3_q;
  logic       tmr0_inc_q, tmr0_inc_d;
  logic       wdtmr_q, wdtmr_d;
  logic       sleeping_q, sleeping_d;

  logic       t0cs, t0se, psa;
  logic [2:0] ps;
  logic       t0_edge, tick, wdt_clr, psc_clr, base_to;
  logic [7:0] mask_tmr;
  logic       fire_tmr;

  assign t0cs = option_q[5];
  assign t0se = option_q[4];
  assign psa  = option_q[3];
  assign ps   = option_q[2:0];

  // s1/s2 synchronise the pin; s3 holds the previous synchronised level
  assign t0_edge = t0se ? (~s2_q & s3_q) : (s2_q & ~s3_q);
  assign tick    = (t0cs ? t0_edge : 1'b1) & ~sleeping_q;

  assign wdt_clr = bus.clrwdt | bus.sleep;
  assign psc_clr = bus.option_wr | (bus.tmr0_wr & ~psa) | (wdt_clr & psa);

  assign mask_tmr = 8'((9'd2 << ps) - 9'd1);
  assign fire_tmr = ((psc_q & mask_tmr) == mask_tmr);

`ifdef MINICPU_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
  logic [7:0]           mask_wdt;
  logic                 fire_wdt;

  assign base_to  = &wdt_q;
  assign mask_wdt = 8'((9'd1 << ps) - 9'd1);
  assign fire_wdt = ((psc_q & mask_wdt) == mask_wdt);

  always_comb begin
    wdt_d = wdt_q + WDT_WIDTH'(1);
    if (wdt_clr) wdt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end

  // A clear in the timeout cycle wins; with PSA=1 the prescaler gates the timeout
  always_comb begin
    wdtmr_d = base_to & ~wdt_clr;
    if (psa) wdtmr_d = base_to & ~psc_clr & fire_wdt;
  end
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^WDT_WIDTH;
  assign base_to        = 1'b0;
  assign wdtmr_d        = 1'b0;
`endif

  always_comb begin
    option_d   = option_q;
    psc_d      = psc_q;
    tmr0_inc_d = 1'b0;
    sleeping_d = sleeping_q;

    if (bus.option_wr) option_d = bus.option_in;

    // Prescaler feeds TMR0 (PSA=0) or counts WDT base timeouts (PSA=1)
    if (psc_clr)             psc_d = '0;
    else if (!psa && tick)   psc_d = psc_q + 8'd1;
    else if (psa && base_to) psc_d = psc_q + 8'd1;

    if (!psa) tmr0_inc_d = tick & ~psc_clr & fire_tmr;
    else      tmr0_inc_d = tick & ~bus.option_wr;

    if (bus.sleep)    sleeping_d = 1'b1;
    else if (wdtmr_d) sleeping_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      option_q   <= 6'b111111;
      psc_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      tmr0_inc_q <= 1'b0;
      wdtmr_q    <= 1'b0;
      sleeping_q <= 1'b0;
    end else begin
      option_q   <= option_d;
      psc_q      <= psc_d;
      s1_q       <= bus.t0cki;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      tmr0_inc_q <= tmr0_inc_d;
      wdtmr_q    <= wdtmr_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign bus.tmr0_inc = tmr0_inc_q;
  assign bus.wdtmr    = wdtmr_q;
  assign bus.option   = option_q;
  assign bus.sleeping = sleeping_q;

endmodule
